// File: rtl/rvee_regfile_if.sv
// rtl/rvee_regfile_if.sv - decode/writeback/exec-bypass bundle of the rvee register file
//
// Ports (master = pipeline side, slave = register file):
//   rs1, rs2            read indices from decode
//   rs1_data, rs2_data  registered read data, one cycle after the index
//   wb_we/wb_rd/wb_data      writeback stream from the mem stage
//   mem_we/mem_rd/mem_data   exec result, bypass only
//   ready               high once the post-reset clear has completed
interface rvee_regfile_if #(
  parameter int N_REGS = 32,
  parameter int XLEN   = 32
);
  localparam int AW = $clog2(N_REGS);

  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            wb_we;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            mem_we;
  logic [AW-1:0]   mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            ready;

  modport master (
    output rs1, rs2, wb_we, wb_rd, wb_data, mem_we, mem_rd, mem_data,
    input  rs1_data, rs2_data, ready
  );

  modport slave (
    input  rs1, rs2, wb_we, wb_rd, wb_data, mem_we, mem_rd, mem_data,
    output rs1_data, rs2_data, ready
  );
endinterface

// File: rtl/rvee_regfile.sv
// rtl/rvee_regfile.sv - rvee integer register file with post-reset clear and optional bypass
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset; restarts the clear sequence
//   rf   rvee_regfile_if.slave: two synchronous read ports, writeback port,
//        exec bypass port, ready
//
// Optional feature macro: RVEE_RF_BYPASS_EN
//   defined   - reads forward mem_data (highest) then wb_data ahead of the array
//   undefined - reads see only the array (pre-write contents); mem port unused
module rvee_regfile #(
  parameter int N_REGS = 32,
  parameter int XLEN   = 32
) (
  input logic          clk,
  input logic          rst,
  rvee_regfile_if.slave rf
);
  localparam int AW = $clog2(N_REGS);

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t          state;
  logic [AW-1:0]   clr_idx;
  logic            ready_q;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] rs2_q;
  logic [XLEN-1:0] rd1_next;
  logic [XLEN-1:0] rd2_next;

  // RAM-style storage: deliberately not reset, zeroed by the CLEAR walk.
  // Entry 0 is never written; x0 is forced to zero on the read path.
  logic [XLEN-1:0] regs [N_REGS];

  assign rf.rs1_data = rs1_q;
  assign rf.rs2_data = rs2_q;
  assign rf.ready    = ready_q;

`ifdef RVEE_RF_BYPASS_EN
  // Later assignments win: x0 over mem bypass over wb bypass over array.
  // The x0 override also keeps a mem_rd=0 / wb_rd=0 result from forwarding.
  always_comb begin
    rd1_next = regs[rf.rs1];
    if (rf.wb_we && (rf.wb_rd == rf.rs1))
      rd1_next = rf.wb_data;
    if (rf.mem_we && (rf.mem_rd == rf.rs1))
      rd1_next = rf.mem_data;
    if (rf.rs1 == '0)
      rd1_next = '0;
  end

  always_comb begin
    rd2_next = regs[rf.rs2];
    if (rf.wb_we && (rf.wb_rd == rf.rs2))
      rd2_next = rf.wb_data;
    if (rf.mem_we && (rf.mem_rd == rf.rs2))
      rd2_next = rf.mem_data;
    if (rf.rs2 == '0)
      rd2_next = '0;
  end
`else
  // Without bypass a same-edge writeback is not seen; the hazard unit stalls.
  always_comb begin
    rd1_next = (rf.rs1 == '0) ? '0 : regs[rf.rs1];
  end

  always_comb begin
    rd2_next = (rf.rs2 == '0) ? '0 : regs[rf.rs2];
  end

  logic unused_mem_port;
  assign unused_mem_port = ^{rf.mem_we, rf.mem_rd, rf.mem_data};
`endif

  // Control FSM with registered outputs. Clear walks indices 1..N_REGS-1,
  // so ready rises on the (N_REGS-1)th edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= CLEAR;
      clr_idx <= AW'(1);
      ready_q <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + AW'(1);
          rs1_q   <= '0;
          rs2_q   <= '0;
          if (clr_idx == AW'(N_REGS - 1)) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          rs1_q <= rd1_next;
          rs2_q <= rd2_next;
        end
        default: begin
          state   <= CLEAR;
          clr_idx <= AW'(1);
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Array write port. Clear writes take the port while in CLEAR, so any
  // writeback arriving then is dropped. Writes to x0 are discarded.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      regs[clr_idx] <= '0;
    end else if (rf.wb_we && (rf.wb_rd != '0)) begin
      regs[rf.wb_rd] <= rf.wb_data;
    end
  end
endmodule

// File: tb/tb_rvee_regfile.sv
// tb/tb_rvee_regfile.sv - self-checking bench for rvee_regfile
module tb_rvee_regfile;
  localparam int N_REGS = 32;
  localparam int XLEN   = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [XLEN-1:0] e1;
    logic [XLEN-1:0] e2;
    string           tag;
  } exp_t;

  exp_t sb[$];

  rvee_regfile_if #(.N_REGS(N_REGS), .XLEN(XLEN)) rf_if ();

  rvee_regfile #(.N_REGS(N_REGS), .XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic wb_we, input logic [4:0] wb_rd, input logic [XLEN-1:0] wb_data,
                       input logic mem_we, input logic [4:0] mem_rd, input logic [XLEN-1:0] mem_data);
    rf_if.rs1      = rs1;
    rf_if.rs2      = rs2;
    rf_if.wb_we    = wb_we;
    rf_if.wb_rd    = wb_rd;
    rf_if.wb_data  = wb_data;
    rf_if.mem_we   = mem_we;
    rf_if.mem_rd   = mem_rd;
    rf_if.mem_data = mem_data;
  endtask

  task automatic expect_rd(input string tag, input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2);
    exp_t e;
    e.e1  = e1;
    e.e2  = e2;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Advance one edge and compare any read result that edge produced.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({e.tag, "_rs1"}, rf_if.rs1_data, e.e1);
      check({e.tag, "_rs2"}, rf_if.rs2_data, e.e2);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!rf_if.ready && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, XLEN'(n), XLEN'(N_REGS - 1));
    check({tag, "_ready"}, XLEN'(rf_if.ready), XLEN'(1));
  endtask

  initial begin
    drive(5'd0, 5'd0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);

    // Reset held for three cycles
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("reset_ready", XLEN'(rf_if.ready), XLEN'(0));
    check("reset_rs1", rf_if.rs1_data, '0);
    check("reset_rs2", rf_if.rs2_data, '0);

    // Release; push a write to r3 for the whole clear, it must be dropped
    rst = 1'b1;
    drive(5'd5, 5'd3, 1'b1, 5'd3, 32'hFFFF_FFFF, 1'b1, 5'd5, 32'h5555_5555);
    wait_ready("clear1");
    check("clear_hold_rs1", rf_if.rs1_data, '0);
    check("clear_hold_rs2", rf_if.rs2_data, '0);

    drive(5'd5, 5'd3, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    expect_rd("post_clear", '0, '0);
    tick();

    // Write r7 then read it on both ports
    drive(5'd0, 5'd0, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 5'd0, '0);
    expect_rd("wr_r7", '0, '0);
    tick();
    drive(5'd7, 5'd7, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    expect_rd("rd_r7", 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    tick();

    // Write to x0 is discarded, also same-edge
    drive(5'd0, 5'd0, 1'b1, 5'd0, 32'h0000_1234, 1'b1, 5'd0, 32'h0000_5678);
    expect_rd("wr_r0_same", '0, '0);
    tick();
    drive(5'd0, 5'd0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    expect_rd("rd_r0", '0, '0);
    tick();

    // Dual-port independence
    drive(5'd0, 5'd0, 1'b1, 5'd1, 32'h1, 1'b0, 5'd0, '0);
    expect_rd("wr_r1", '0, '0);
    tick();
    drive(5'd0, 5'd0, 1'b1, 5'd2, 32'h2, 1'b0, 5'd0, '0);
    expect_rd("wr_r2", '0, '0);
    tick();
    drive(5'd2, 5'd1, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    expect_rd("dual", 32'h2, 32'h1);
    tick();

    // Bypass priority on r4 (holds 0x11 beforehand)
    drive(5'd0, 5'd0, 1'b1, 5'd4, 32'h11, 1'b0, 5'd0, '0);
    expect_rd("wr_r4", '0, '0);
    tick();
    drive(5'd4, 5'd1, 1'b1, 5'd4, 32'h22, 1'b1, 5'd4, 32'h33);
`ifdef RVEE_RF_BYPASS_EN
    expect_rd("byp_mem", 32'h33, 32'h1);
`else
    expect_rd("nobyp_old", 32'h11, 32'h1);
`endif
    tick();
    drive(5'd4, 5'd2, 1'b1, 5'd4, 32'h22, 1'b0, 5'd4, 32'h33);
    expect_rd("byp_wb", 32'h22, 32'h2);
    tick();
    drive(5'd0, 5'd4, 1'b0, 5'd0, '0, 1'b1, 5'd0, 32'h33);
    expect_rd("byp_x0", '0, 32'h22);
    tick();
    // wb bypass alone on a fresh register, rs2 only
    drive(5'd4, 5'd6, 1'b1, 5'd6, 32'h66, 1'b1, 5'd5, 32'h55);
`ifdef RVEE_RF_BYPASS_EN
    expect_rd("byp_wb_r6", 32'h22, 32'h66);
`else
    expect_rd("nobyp_r6", 32'h22, '0);
`endif
    tick();
    drive(5'd6, 5'd5, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    expect_rd("rd_r6", 32'h66, '0);
    tick();

    // Write r9 and confirm it landed
    drive(5'd0, 5'd0, 1'b1, 5'd9, 32'hA5A5_A5A5, 1'b0, 5'd0, '0);
    expect_rd("wr_r9", '0, '0);
    tick();
    drive(5'd9, 5'd7, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    expect_rd("rd_r9", 32'hA5A5_A5A5, 32'hDEAD_BEEF);
    tick();

    // Asynchronous reset mid-RUN, then again at clear index 10
    rst = 1'b0;
    #1;
    check("async_rst_ready", XLEN'(rf_if.ready), XLEN'(0));
    check("async_rst_rs1", rf_if.rs1_data, '0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    check("mid_clear_ready", XLEN'(rf_if.ready), XLEN'(0));
    rst = 1'b0;
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    wait_ready("clear2");

    drive(5'd9, 5'd7, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    expect_rd("rd_r9_cleared", '0, '0);
    tick();

    check("sb_drained", XLEN'(sb.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rvee_regfile.md
# rvee_regfile

Integer register file for the rvee pipeline: the storage end of the decode/exec/mem register-file interface. It serves two synchronous read ports to decode and accepts the writeback stream from the mem stage. It optionally bypasses in-flight results from the exec (mem-port) and writeback paths. Storage is a non-resettable RAM-style array, so a clear sequencer zeroes it after reset and holds `ready` low until it finishes.

## Interface
- N_REGS, 32, number of architectural registers; power of two, ≥4; x0 hardwired to zero
- XLEN, 32, register width in bits
- AW (local), $clog2(N_REGS), register index width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset; one clock domain, no other reset
- rs1, rs2  in  AW  read indices from decode, sampled every edge
- rs1_data, rs2_data  out  XLEN  registered read data, valid one cycle after index
- wb_we  in  1  writeback enable from mem stage
- wb_rd  in  AW  writeback destination
- wb_data  in  XLEN  writeback value
- mem_we  in  1  exec result valid for bypass; never written to the array
- mem_rd  in  AW  exec result destination
- mem_data  in  XLEN  exec result value
- ready  out  1  high once the clear sequence has completed; pipeline stalls while low

## Operation
- States: CLEAR, RUN. Reset forces CLEAR with clear index = 1.
- CLEAR: each edge writes 0 to array[index] and increments index. At the edge that writes index N_REGS-1, the state moves to RUN and ready becomes 1.
- CLEAR: wb writes are dropped, the mem port is ignored, and rs1_data/rs2_data are held at 0.
- RUN write: at an edge where wb_we=1 and wb_rd≠0, array[wb_rd] ← wb_data. Writes with wb_rd=0 are discarded.
- RUN read (per port, shown for rs1): at each edge rs1_data ← the first match, in priority order:
  - 0 if rs1=0
  - mem_data if mem_we=1 and mem_rd=rs1 (bypass; mem is the younger instruction)
  - wb_data if wb_we=1 and wb_rd=rs1 (bypass)
  - otherwise array[rs1], the pre-write contents
- Both ports are independent and may address the same register.
- mem_we with mem_rd=0 never bypasses.

## Timing
- Reset values: rs1_data=0, rs2_data=0, ready=0, state=CLEAR, clear index=1. Array contents are undefined until cleared.
- Reset asserts asynchronously at any time, including mid-CLEAR or mid-RUN, and restarts the full clear sequence. The array is re-zeroed; in-flight writes are lost.
- Clear latency: ready rises after exactly N_REGS-1 rising edges following reset deassertion (31 edges at default).
- Read latency: 1 cycle. The index presented in cycle N yields data in cycle N+1, held until the next edge.
- Write latency: a wb write at edge E is visible through the array path to an index sampled at edge E+1 or later.
- Same-edge write and read of the same register returns the new value only via bypass (see Configuration).

## Configuration
- RVEE_RF_BYPASS_EN defined:
  - mem and wb bypass muxes are present as described above.
- RVEE_RF_BYPASS_EN undefined:
  - mem_we, mem_rd and mem_data are unused.
  - Reads return 0 for x0, otherwise array[rsN].
  - A same-edge wb write to the read register returns the old value; the hazard unit must stall one cycle.
  - The clear sequence, x0 handling and latency are unchanged.

## Test plan
- Reset then clear (N_REGS=32):
  - Hold rst=0 for 3 cycles and release. ready=0 for 31 edges, then 1.
  - rs1=5 then yields rs1_data=0.
  - A wb write to r3 during CLEAR is dropped; a later read of r3 returns 0.
- Write/read:
  - In RUN, write r7←0xDEADBEEF at edge E.
  - Present rs1=7, rs2=7 at E+1. Both data outputs = 0xDEADBEEF one cycle later.
  - A write to r0 of 0x1234 leaves reads of r0 = 0.
- Bypass priority (RVEE_RF_BYPASS_EN defined):
  - r4 holds 0x11. In the same cycle: rs1=4, wb_we=1 wb_rd=4 wb_data=0x22, mem_we=1 mem_rd=4 mem_data=0x33 → rs1_data=0x33.
  - Drop mem_we → rs1_data=0x22.
  - With mem_rd=0 and rs1=0 → rs1_data=0.
- No bypass (macro undefined):
  - Same stimulus as the bypass-priority case → rs1_data=0x11.
  - The next cycle with rs1=4 → rs1_data=0x22.
- Reset mid-operation:
  - Write r9←0xA5A5A5A5, assert rst for 1 cycle at clear index 10 of a second clear, then release.
  - ready stays low for a full 31 edges; r9 then reads 0.
- Dual-port independence:
  - r1=0x1, r2=0x2. rs1=2 and rs2=1 in the same cycle → rs1_data=0x2, rs2_data=0x1.
